// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the iteration-counter width helper.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, since it stops there on exit from BUSY.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, pulling the
// next dividend bit (held in the top of quo) into the remainder. Subtract the
// divisor when it fits and record a 1 in the new quotient LSB.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvsr_ext;
    logic             take;

    // Compare/subtract at WIDTH+2 bits so the shifted remainder never overflows.
    always_comb begin
        shifted  = {rem_in, quo_in[WIDTH-1]};
        dvsr_ext = {2'b00, dvsr};
        take     = (shifted >= dvsr_ext);
        rem_out  = take ? (WIDTH+1)'(shifted - dvsr_ext) : shifted[WIDTH:0];
        quo_out  = {quo_in[WIDTH-2:0], take};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with registered quotient/remainder.
// One operand pair per start handshake, one result per output handshake.
// Optional build macro: SEQ_DIV_FAST_PATH_EN. When it is defined, a divide by
// zero or a dividend smaller than the divisor skips BUSY and goes straight to DONE.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. start_ready is high only in IDLE. out_valid is high only
// in DONE. Outputs do not change while out_valid is high. start_valid seen
// outside IDLE is ignored and not queued.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             accept;
    logic             release_res;
    logic             last_step;
    logic             dvsr_zero;
    logic             fast;

    assign start_ready = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = start_valid && start_ready;
    assign release_res = out_valid && out_ready;
    assign last_step   = (state == BUSY) && (cnt == CW'(WIDTH - 1));
    assign dvsr_zero   = (dvsr_r == '0);

`ifdef SEQ_DIV_FAST_PATH_EN
    // The answer is known at accept time: q=0, r=dividend.
    assign fast = (divisor == '0) || (dividend < divisor);
`else
    assign fast = 1'b0;
`endif

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .dvsr    (dvsr_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY (or DONE on fast path) -> DONE -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)      state_nxt = fast ? DONE : BUSY;
            BUSY: if (last_step)   state_nxt = DONE;
            DONE: if (release_res) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate in BUSY, load results entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvsr_r      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            rem_r  <= '0;
            quo_r  <= dividend;
            dvsr_r <= divisor;
            if (fast) begin
                quotient    <= '0;
                remainder   <= dividend;
                div_by_zero <= (divisor == '0);
            end
        end else if (state == BUSY) begin
            rem_r <= step_rem;
            quo_r <= step_quo;
            cnt   <= cnt + 1'b1;
            if (last_step) begin
                // A zero divisor makes every step "fit", so the remainder is already
                // the dividend. Only the all-ones quotient needs overriding.
                quotient    <= dvsr_zero ? '0 : step_quo;
                remainder   <= step_rem[WIDTH-1:0];
                div_by_zero <= dvsr_zero;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. It runs directed cases, a mid-operation
// reset and a randomized back-to-back phase. All of these are scored against
// plain / and % arithmetic.
// Latency is counted in rising edges, including the accept edge, up to the edge
// that raises out_valid.
module tb_seq_divider;

    localparam int W      = 8;
    localparam int N_RAND = 1000;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Scoreboard entries are {dbz, q, r}.
    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock and edge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Absolute time limit.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {1'b1, {W{1'b0}}, a};
        return {1'b0, a / b, a % b};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_DIV_FAST_PATH_EN
        if (b == '0 || a < b) return 1;
`endif
        return W + 1;
    endfunction

    task automatic check_result(input string tag, input logic [2*W:0] e);
        check({tag, " q"}, quotient, e[2*W-1:W]);
        check({tag, " r"}, remainder, e[W-1:0]);
        check({tag, " dbz"}, div_by_zero, e[2*W]);
    endtask

    // Driver: issue one op, measure latency, optionally hold off out_ready, then retire.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input string tag);
        int           acc_cyc;
        int           guard;
        logic [2*W:0] e;
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        start_valid = 1'b1;
        out_ready   = 1'b0;
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " start_ready"}, start_ready, 1);
        exp_q.push_back(ref_div(a, b));
        @(negedge clk);
        acc_cyc     = cyc;
        start_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " latency"}, cyc - acc_cyc + 1, exp_lat(a, b));
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            // Offer a different op while busy; it must be ignored.
            start_valid = 1'b1;
            dividend    = W'($urandom);
            divisor     = W'($urandom);
            check({tag, " hold start_ready"}, start_ready, 0);
            check({tag, " hold out_valid"}, out_valid, 1);
            check_result({tag, " hold"}, e);
            @(negedge clk);
        end
        start_valid = 1'b0;
        check_result(tag, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " released"}, out_valid, 0);
        check({tag, " ready again"}, start_ready, 1);
    endtask

    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [2*W:0] e_r;
    logic         pending;
    logic         saw_valid;
    int           n_iss;
    int           n_done;
    int           guard_r;

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        out_ready   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (3) @(negedge clk);
        check("reset start_ready", start_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset q", quotient, 0);
        check("reset r", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd100, 8'd7,   0,  "100/7");
        run_op(8'd255, 8'd0,   0,  "255/0");
        run_op(8'd200, 8'd1,   0,  "200/1");
        run_op(8'd5,   8'd9,   0,  "5/9");
        run_op(8'd255, 8'd255, 0,  "255/255");
        run_op(8'd0,   8'd3,   0,  "0/3");
        run_op(8'd100, 8'd7,   20, "backpressure 100/7");

        // Reset during the 4th iteration of 50/3.
        @(negedge clk);
        dividend    = 8'd50;
        divisor     = 8'd3;
        start_valid = 1'b1;
        check("rst op start_ready", start_ready, 1);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst start_ready", start_ready, 1);
        check("midrst q", quotient, 0);
        check("midrst r", remainder, 0);
        check("midrst dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw_valid = saw_valid | out_valid;
        end
        check("midrst no pulse", saw_valid, 0);
        run_op(8'd50, 8'd3, 0, "50/3 after reset");

        // Randomized back-to-back traffic with random out_ready.
        pending = 1'b0;
        n_iss   = 0;
        n_done  = 0;
        guard_r = 0;
        while (n_done < N_RAND && guard_r < 60000) begin
            @(negedge clk);
            guard_r++;
            if (!pending) begin
                if (n_iss < N_RAND && $urandom_range(0, 3) != 0) begin
                    ra = W'($urandom);
                    case ($urandom_range(0, 4))
                        0:       rb = '0;
                        1:       rb = W'($urandom_range(1, 15));
                        2:       rb = ra;
                        default: rb = W'($urandom);
                    endcase
                    dividend    = ra;
                    divisor     = rb;
                    start_valid = 1'b1;
                    pending     = 1'b1;
                end else begin
                    start_valid = 1'b0;
                    dividend    = W'($urandom);
                    divisor     = W'($urandom);
                end
            end
            if (pending && start_ready) begin
                exp_q.push_back(ref_div(dividend, divisor));
                n_iss++;
                pending = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand spurious result", out_valid, 0);
                end else begin
                    e_r = exp_q.pop_front();
                    check_result("rand", e_r);
                end
                n_done++;
            end
        end
        @(negedge clk);
        start_valid = 1'b0;
        out_ready   = 1'b0;
        check("rand results retired", n_done, N_RAND);
        check("rand scoreboard empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
